// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential 16x16 multiplier among NREQ
// requesters and returns each product (or a watchdog abort) on a valid/ready channel.
module mult_share_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 40,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [16*NREQ-1:0]   req_a_i,
  input  logic [16*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 rsp_valid_o,
  output logic [IW-1:0]        rsp_id_o,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_err_o,
  input  logic                 rsp_ready_i,
  output logic                 mul_start_o,
  output logic [15:0]          mul_a_o,
  output logic [15:0]          mul_b_o,
  input  logic                 mul_ready_i,
  input  logic [31:0]          mul_result_i
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [IW:0]   NREQ_W  = (IW+1)'(NREQ);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]   wdog_q;
  logic [15:0]     mul_a_q, mul_b_q;
  logic            mul_start_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [IW-1:0]   rsp_id_q;
  logic [31:0]     rsp_result_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_id;
  logic            found;
  logic [IW:0]     sum;
  logic [15:0]     a_sel, b_sel;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req_valid_i[sum[IW-1:0]]) begin
        found           = 1'b1;
        gnt[sum[IW-1:0]] = 1'b1;
        gnt_id          = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        a_sel = req_a_i[16*k +: 16];
        b_sel = req_b_i[16*k +: 16];
      end
    end
  end

  assign rr_ptr_d    = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      wdog_q       <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          mul_a_q     <= a_sel;
          mul_b_q     <= b_sel;
          rsp_id_q    <= gnt_id;
          rr_ptr_q    <= rr_ptr_d;
          mul_start_q <= 1'b1;
          state_q     <= ISSUE;
        end
        // mul_ready is still stale from the previous op here, so it is not looked at.
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mul_ready_i) begin
            rsp_result_q <= mul_result_i;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (wdog_q == WD_LAST) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;
  assign mul_start_o  = mul_start_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural shift-add multiplier.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0, req_ready;
  logic [16*NREQ-1:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_err, rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic mul_start, mul_ready;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_result;

  mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
    .rsp_ready_i(rsp_ready),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_ready_i(mul_ready), .mul_result_i(mul_result));

  always #5 clk = ~clk;

  // Multiplier model: one b bit per cycle, ready as soon as no higher b bits remain.
  logic [31:0] m_acc = '0, m_ma = '0, m_res = '0;
  logic [15:0] m_mb = '0;
  logic m_busy = 1'b0, m_rdy = 1'b0, tie0 = 1'b0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_acc <= '0; m_ma <= {16'h0, mul_a}; m_mb <= mul_b; m_busy <= 1'b1; m_rdy <= 1'b0;
    end else if (m_busy) begin
      if ((m_mb >> 1) == 16'h0) begin
        m_res  <= m_acc + (m_mb[0] ? m_ma : 32'h0);
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_acc <= m_acc + (m_mb[0] ? m_ma : 32'h0);
        m_ma  <= m_ma << 1;
        m_mb  <= m_mb >> 1;
      end
    end
  end
  assign mul_ready  = m_rdy & ~tie0;
  assign mul_result = m_res;

  typedef struct {int id; logic [31:0] res; logic err; int minl; int maxl;} exp_t;
  exp_t exp_q[$];
  int   gnt_q[$];
  int   g_q[$];
  int   errors = 0, checks = 0, cyc = 0, starts = 0, vcyc = 0;
  logic vseen = 1'b0;
  logic [NREQ-1:0] hs_pend = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic raise(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] res, input logic err, input int minl, input int maxl);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i] = 1'b1;
    gnt_q.push_back(i);
    exp_q.push_back('{i, res, err, minl, maxl});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || req_valid != '0) && n < 400) begin
      @(posedge clk); n++;
    end
    chk({name, "_drained"}, 64'(n >= 400), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters drop valid right after their handshake edge.
  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (hs_pend[i]) req_valid[i] = 1'b0;
    hs_pend = '0;
  end

  // Monitor: grant order, handshake timestamps, response scoreboard.
  always @(negedge clk) begin
    logic [NREQ-1:0] hs;
    exp_t e;
    int g, gi;
    if (mul_start) starts++;
    hs = req_valid & req_ready;
    if (hs != '0) begin
      gi = gnt_q.size() ? gnt_q.pop_front() : 0;
      chk("grant_onehot", 64'(hs), 64'((NREQ)'(1) << gi));
      g_q.push_back(cyc);
      hs_pend = hs;
    end
    if (rsp_valid) begin
      if (!vseen) begin vseen = 1'b1; vcyc = cyc; end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got id=%0d result=%0h with nothing expected", rsp_id, rsp_result);
        end else begin
          e = exp_q.pop_front();
          g = g_q.size() ? g_q.pop_front() : -1000;
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          checks++;
          if (vcyc - g < e.minl || vcyc - g > e.maxl) begin
            errors++;
            $display("FAIL rsp_latency: got %0d cycles required %0d..%0d (id %0d)", vcyc - g, e.minl, e.maxl, e.id);
          end
        end
        vseen = 1'b0;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"},  64'(rsp_valid), 0);
    chk({tag, "_req_ready"},  64'(req_ready), 0);
    chk({tag, "_mul_start"},  64'(mul_start), 0);
    chk({tag, "_mul_ab"},     64'({mul_a, mul_b}), 0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 0);
    chk({tag, "_rsp_err_id"}, 64'({rsp_err, rsp_id}), 0);
  endtask

  initial begin
    int n, s0;
    #2 chk_zero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // single request, then move rr_ptr back to 0
    s0 = starts;
    raise(0, 16'd3, 16'd5, 32'd15, 1'b0, 3, 6);
    drain("t1");
    chk("t1_start_pulses", 64'(starts - s0), 64'd1);
    raise(3, 16'd2, 16'd3, 32'd6, 1'b0, 3, 5);
    drain("t1b");

    // all four contending, requester 0 comes back after its grant
    raise(0, 16'd100,   16'd200,    32'd20000,      1'b0, 3, 11);
    raise(1, 16'd1234,  16'd2,      32'd2468,       1'b0, 3, 5);
    raise(2, 16'h1000,  16'h0100,   32'h0010_0000,  1'b0, 3, 12);
    raise(3, 16'hABCD,  16'h0003,   32'h0002_0367,  1'b0, 3, 5);
    n = 0;
    while (req_valid[0] && n < 50) begin @(posedge clk); #2; n++; end
    raise(0, 16'h0011, 16'h0011, 32'h0000_0121, 1'b0, 3, 8);
    drain("t2");

    // width and zero-operand boundaries
    raise(2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 3, 19);
    drain("t3a");
    raise(3, 16'd7, 16'd0, 32'd0, 1'b0, 3, 4);
    drain("t3b");

    // response back-pressure
    rsp_ready = 1'b0;
    raise(1, 16'h0010, 16'h0020, 32'h0000_0200, 1'b0, 3, 9);
    raise(2, 16'h0101, 16'h0003, 32'h0000_0303, 1'b0, 3, 5);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_hold", 64'({rsp_valid, rsp_err, 2'(rsp_id), rsp_result}), 64'({1'b1, 1'b0, 2'd1, 32'h200}));
      chk("t4_no_grant", 64'(req_ready), 0);
    end
    chk("t4_no_start", 64'(starts - s0), 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain("t4");

    // watchdog abort, then a normal op
    tie0 = 1'b1;
    raise(0, 16'd5, 16'd6, 32'd0, 1'b1, TIMEOUT + 2, TIMEOUT + 2);
    drain("t5a");
    tie0 = 1'b0;
    raise(1, 16'd6, 16'd7, 32'd42, 1'b0, 3, 6);
    drain("t5b");

    // reset in the middle of WAIT
    raise(2, 16'h1234, 16'h8000, 32'h0, 1'b0, 3, 19);
    n = 0;
    while (!mul_start && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_zero("midop_reset");
    exp_q.delete(); g_q.delete(); gnt_q.delete();
    vseen = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    raise(2, 16'd9, 16'd9, 32'd81, 1'b0, 3, 7);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
